// File: rtl/iter_stream_pkg.sv
// iter_stream shared types.
// One-hot sequencer state; each bit drives an output directly.
package iter_stream_pkg;

  localparam int IDLE_B = 0;
  localparam int RUN_B  = 1;
  localparam int DONE_B = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_e;

endpackage

// File: rtl/iter_stream_if.sv
// Valid/ready index stream between sequencer and sink.
// Carries the index and the last-item flag.
interface iter_stream_if #(
  parameter int WIDTH = 5
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/iter_stream_counter.sv
// Index counter with synchronous clear.
// Saturates at MAX_VALUE so it never wraps.
module iter_stream_counter #(
  parameter int MAX_VALUE = 16,
  parameter int WIDTH     = $clog2(MAX_VALUE + 1)
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && count_q != TOP) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/iter_stream.sv
// Push iterator: emits 0..MAX_VALUE-1 on a valid/ready
// stream per start pulse, then pulses done for one cycle.
module iter_stream
  import iter_stream_pkg::*;
#(
  parameter int MAX_VALUE = 16,
  parameter int WIDTH     = $clog2(MAX_VALUE + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  iter_stream_if.master  m,
  output logic           busy,
  output logic           done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_VALUE - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] cnt;
  logic             xfer;
  logic             last;
  logic             clr;

  assign xfer = state_q[RUN_B] && m.ready;
  assign last = state_q[RUN_B] && (cnt == LAST);
  assign clr  = reset || (state_q[IDLE_B] && start);

  iter_stream_counter #(
    .MAX_VALUE (MAX_VALUE),
    .WIDTH     (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .clr_i   (clr),
    .en_i    (xfer),
    .count_o (cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[IDLE_B]: if (start) state_d = ST_RUN;
      state_q[RUN_B]:  if (xfer && last) state_d = ST_DONE;
      state_q[DONE_B]: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are flop bits of the one-hot state; no ready->valid path.
  assign m.valid = state_q[RUN_B];
  assign m.data  = cnt;
  assign m.last  = last;
  assign busy    = state_q[RUN_B];
  assign done    = state_q[DONE_B];

endmodule

// File: tb/tb_iter_stream.sv
// Directed bench for iter_stream (MAX_VALUE 4, 1, 16).
// Random-ready scoreboard on the 16-item instance.
module tb_iter_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start4 = 1'b0;
  logic start1 = 1'b0;
  logic start16 = 1'b0;
  logic busy4, done4, busy1, done1, busy16, done16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_stream_if #(.WIDTH(3)) if4 ();
  iter_stream_if #(.WIDTH(1)) if1 ();
  iter_stream_if #(.WIDTH(5)) if16 ();

  iter_stream #(.MAX_VALUE(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .start (start4),
    .m     (if4),
    .busy  (busy4),
    .done  (done4)
  );

  iter_stream #(.MAX_VALUE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .m     (if1),
    .busy  (busy1),
    .done  (done1)
  );

  iter_stream #(.MAX_VALUE(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .start (start16),
    .m     (if16),
    .busy  (busy16),
    .done  (done16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic c4(input string tag, input logic v,
                    input logic [31:0] d, input logic l,
                    input logic b, input logic dn);
    chk({tag, ".valid"}, 32'(if4.valid), 32'(v));
    chk({tag, ".data"}, 32'(if4.data), d);
    chk({tag, ".last"}, 32'(if4.last), 32'(l));
    chk({tag, ".busy"}, 32'(busy4), 32'(b));
    chk({tag, ".done"}, 32'(done4), 32'(dn));
  endtask

  initial begin
    int ed [7];
    logic rd [7];
    int exp_d;
    int lasts;
    int dones;
    int cyc;
    bit fin;

    if4.ready  = 1'b0;
    if1.ready  = 1'b0;
    if16.ready = 1'b0;

    // reset state
    tick();
    tick();
    reset = 1'b0;
    c4("rst4", 0, 0, 0, 0, 0);
    chk("rst1.valid", 32'(if1.valid), 0);
    chk("rst1.done", 32'(done1), 0);
    chk("rst16.valid", 32'(if16.valid), 0);
    chk("rst16.data", 32'(if16.data), 0);

    // basic run
    if4.ready = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c4("basic", 1, 32'(k), k == 3, 1, 0);
      tick();
    end
    c4("basic_done", 0, 4, 0, 0, 1);
    tick();
    c4("basic_idle", 0, 4, 0, 0, 0);

    // backpressure: ready low cycles 2-4
    ed = '{0, 1, 1, 1, 1, 2, 3};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if4.ready = rd[i];
      c4("bp", 1, 32'(ed[i]), ed[i] == 3, 1, 0);
      tick();
    end
    c4("bp_done", 0, 4, 0, 0, 1);
    tick();
    chk("bp_idle.done", 32'(done4), 0);

    // start while busy, start in done dropped
    if4.ready = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    c4("sb1", 1, 0, 0, 1, 0);
    tick();
    start4 = 1'b1;
    c4("sb2", 1, 1, 0, 1, 0);
    tick();
    start4 = 1'b0;
    c4("sb3", 1, 2, 0, 1, 0);
    tick();
    c4("sb4", 1, 3, 1, 1, 0);
    tick();
    c4("sb_done", 0, 4, 0, 0, 1);
    start4 = 1'b1;
    tick();
    chk("sb_drop.valid", 32'(if4.valid), 0);
    chk("sb_drop.busy", 32'(busy4), 0);
    chk("sb_drop.done", 32'(done4), 0);
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c4("sb_run2", 1, 32'(k), k == 3, 1, 0);
      tick();
    end
    c4("sb_run2_done", 0, 4, 0, 0, 1);
    tick();

    // reset mid-run
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    c4("mr_pre", 1, 2, 0, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c4("mr_rst", 0, 0, 0, 0, 0);
    tick();
    c4("mr_nodone", 0, 0, 0, 0, 0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c4("mr_run", 1, 32'(k), k == 3, 1, 0);
      tick();
    end
    c4("mr_done", 0, 4, 0, 0, 1);
    tick();

    // MAX_VALUE = 1
    if1.ready = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("m1.valid", 32'(if1.valid), 1);
    chk("m1.data", 32'(if1.data), 0);
    chk("m1.last", 32'(if1.last), 1);
    chk("m1.busy", 32'(busy1), 1);
    tick();
    chk("m1_done.valid", 32'(if1.valid), 0);
    chk("m1_done.done", 32'(done1), 1);
    chk("m1_done.data", 32'(if1.data), 1);
    tick();
    chk("m1_idle.done", 32'(done1), 0);

    // random ready, 200 runs of 16
    dones = 0;
    for (int r = 0; r < 200; r++) begin
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      exp_d = 0;
      lasts = 0;
      fin = 1'b0;
      cyc = 0;
      while (!fin && cyc < 200) begin
        if16.ready = 1'($urandom_range(0, 1));
        if (if16.valid) begin
          chk("rnd.last_pos", 32'(if16.last),
              32'(exp_d == 15));
        end
        if (if16.valid && if16.ready) begin
          chk("rnd.data", 32'(if16.data), 32'(exp_d));
          if (if16.last) lasts++;
          exp_d++;
        end
        tick();
        cyc++;
        if (done16) begin
          dones++;
          fin = 1'b1;
        end
      end
      chk("rnd.timeout", 32'(fin), 1);
      chk("rnd.items", 32'(exp_d), 16);
      chk("rnd.lasts", 32'(lasts), 1);
      tick();
    end
    chk("rnd.dones", 32'(dones), 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
